// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled stepping through five selectable patterns,
// with mode changes deferred to the next step boundary.
module led_pattern_gen #(
    parameter int          LED_NUM       = 4,
    parameter int          CNT_W         = 24,
    parameter int unsigned DEFAULT_TICKS = 10
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               en,
    input  logic [CNT_W-1:0]   period,
    input  logic [2:0]         mode_sel,
    input  logic               mode_wr,
    output logic [LED_NUM-1:0] led,
    output logic               step_tick,
    output logic               cfg_pending
);

    typedef enum logic [2:0] {
        MODE_ROL   = 3'd0,
        MODE_ROR   = 3'd1,
        MODE_PING  = 3'd2,
        MODE_COUNT = 3'd3,
        MODE_BLINK = 3'd4
    } mode_t;

    localparam logic [LED_NUM-1:0] LED_ONE = LED_NUM'(1);
    localparam logic [LED_NUM-1:0] LED_MSB = LED_ONE << (LED_NUM - 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [LED_NUM-1:0] led_q, led_d;
    logic               step_tick_q, step_tick_d;
    logic               cfg_pending_q, cfg_pending_d;
    mode_t              mode_q, mode_d;
    mode_t              pend_q, pend_d;
    logic               dir_up_q, dir_up_d;
    logic               tick;
    logic               wr_valid;

    assign tick     = en && (cnt_q == period_q);
    assign wr_valid = mode_wr && (mode_sel <= 3'd4);

    always_comb begin
        cnt_d         = cnt_q;
        period_d      = period_q;
        led_d         = led_q;
        step_tick_d   = tick;
        cfg_pending_d = cfg_pending_q;
        mode_d        = mode_q;
        pend_d        = pend_q;
        dir_up_d      = dir_up_q;

        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        if (tick) begin
            period_d = period;
            if (cfg_pending_q) begin
                mode_d        = pend_q;
                cfg_pending_d = 1'b0;
                case (pend_q)
                    MODE_ROL:   led_d = LED_ONE;
                    MODE_ROR:   led_d = LED_MSB;
                    MODE_PING: begin
                        led_d    = LED_ONE;
                        dir_up_d = 1'b1;
                    end
                    MODE_COUNT: led_d = '0;
                    MODE_BLINK: led_d = '1;
                    default:    led_d = led_q;
                endcase
            end else begin
                case (mode_q)
                    MODE_ROL:   led_d = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
                    MODE_ROR:   led_d = {led_q[0], led_q[LED_NUM-1:1]};
                    MODE_PING: begin
                        // Direction flips in the same step that lands on an end bit,
                        // so each end is shown for exactly one step.
                        if (dir_up_q) begin
                            led_d = led_q << 1;
                            if (led_q[LED_NUM-2]) dir_up_d = 1'b0;
                        end else begin
                            led_d = led_q >> 1;
                            if (led_q[1]) dir_up_d = 1'b1;
                        end
                    end
                    MODE_COUNT: led_d = led_q + LED_NUM'(1);
                    MODE_BLINK: led_d = ~led_q;
                    default:    led_d = led_q;
                endcase
            end
        end

        // A write in the same cycle as a tick lands after the apply above.
        if (wr_valid) begin
            pend_d        = mode_t'(mode_sel);
            cfg_pending_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q         <= '0;
            period_q      <= CNT_W'(DEFAULT_TICKS);
            led_q         <= LED_ONE;
            step_tick_q   <= 1'b0;
            cfg_pending_q <= 1'b0;
            mode_q        <= MODE_ROL;
            pend_q        <= MODE_ROL;
            dir_up_q      <= 1'b1;
        end else begin
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            led_q         <= led_d;
            step_tick_q   <= step_tick_d;
            cfg_pending_q <= cfg_pending_d;
            mode_q        <= mode_d;
            pend_q        <= pend_d;
            dir_up_q      <= dir_up_d;
        end
    end

    assign led         = led_q;
    assign step_tick   = step_tick_q;
    assign cfg_pending = cfg_pending_q;

endmodule
